// File: rtl/muldiv_unit_if.sv
// Request/response bundle for muldiv_unit: operands, funct3 and rd in; busy/done/result/rd back.
// master = issuing side (decode/register bank), slave = muldiv_unit.
// Vectors are ascending-ranged, index 0 is the MSB.
interface muldiv_unit_if #(
  parameter int BITS = 64,
  parameter int REGS = 32
);
  localparam int AW = $clog2(REGS);

  logic            start;
  logic [0:2]      op;
  logic [0:BITS-1] rs1_data;
  logic [0:BITS-1] rs2_data;
  logic [0:AW-1]   rd_in;
  logic            busy;
  logic            done;
  logic [0:BITS-1] result;
  logic [0:AW-1]   rd_out;

  modport master (
    output start, op, rs1_data, rs2_data, rd_in,
    input  busy, done, result, rd_out
  );

  modport slave (
    input  start, op, rs1_data, rs2_data, rd_in,
    output busy, done, result, rd_out
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit, one operation in flight, non-pipelined.
// Latency: done rises BITS+1 cycles after accept; divide special cases rise 2 cycles after accept.
// Backpressure: none queued; start is only sampled in IDLE and is ignored while busy.
// Ports: clk, rst_n (async active-low); io.start/op/rs1_data/rs2_data/rd_in request,
//        io.busy status, io.done one-cycle write strobe with io.result/io.rd_out (registered, held).
module muldiv_unit #(
  parameter int BITS = 64,
  parameter int REGS = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  muldiv_unit_if.slave  io
);
  localparam int AW = $clog2(REGS);
  localparam int CW = $clog2(BITS);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_nx;

  // Descending local copies of the ascending ports; assignment is positional, so MSB maps to MSB.
  logic [2:0]      op_in;
  logic [BITS-1:0] a_in;
  logic [BITS-1:0] b_in;

  logic [2:0]      op_q;
  logic [AW-1:0]   rd_q;
  logic [BITS-1:0] m_q;        // multiplicand (mul) or divisor (div) magnitude
  logic [BITS-1:0] hi;         // product high half / partial remainder / special result
  logic [BITS-1:0] lo;         // product low half + multiplier / quotient + dividend
  logic            neg_q;      // negate product or quotient
  logic            neg_r;      // negate remainder (dividend sign)
  logic            special_q;
  logic [CW-1:0]   cnt;
  logic [BITS-1:0] result_q;
  logic [AW-1:0]   rd_out_q;
  logic            done_q;

  assign op_in = io.op;
  assign a_in  = io.rs1_data;
  assign b_in  = io.rs2_data;

  // Request decode, evaluated in IDLE.
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf, special;
  logic [BITS-1:0] a_mag, b_mag, spec_val;

  assign is_div   = op_in[2];
  assign sgn_a    = is_div ? ~op_in[0] : (op_in[1:0] != 2'b11);
  assign sgn_b    = is_div ? ~op_in[0] : ~op_in[1];
  assign a_neg    = sgn_a & a_in[BITS-1];
  assign b_neg    = sgn_b & b_in[BITS-1];
  assign a_mag    = a_neg ? -a_in : a_in;
  assign b_mag    = b_neg ? -b_in : b_in;
  assign div_zero = is_div && (b_in == '0);
  assign div_ovf  = is_div && !op_in[0] && (a_in == {1'b1, {(BITS-1){1'b0}}}) && (b_in == '1);
  assign special  = div_zero || div_ovf;
  assign spec_val = div_zero ? (op_in[1] ? a_in : '1) : (op_in[1] ? '0 : a_in);

  // One shift-add multiply step: conditionally add, then shift {carry,hi,lo} right by one.
  logic [BITS:0] mul_sum;
  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, m_q} : '0);

  // One restoring divide step: shift next dividend bit into the remainder, subtract if it fits.
  logic [BITS:0]   div_sh;
  logic            div_ge;
  logic [BITS-1:0] div_sub;
  assign div_sh  = {hi, lo[BITS-1]};
  assign div_ge  = div_sh >= {1'b0, m_q};
  assign div_sub = div_sh[BITS-1:0] - m_q;

  // Sign correction and result select.
  logic [2*BITS-1:0] prod, prod_s;
  logic [BITS-1:0]   quo, rem, fix_val;
  assign prod   = {hi, lo};
  assign prod_s = neg_q ? -prod : prod;
  assign quo    = neg_q ? -lo : lo;
  assign rem    = neg_r ? -hi : hi;

  always_comb begin
    fix_val = hi;
    if (!special_q) begin
      if (op_q[2])                 fix_val = op_q[1] ? rem : quo;
      else if (op_q[1:0] == 2'b00) fix_val = prod_s[BITS-1:0];
      else                         fix_val = prod_s[2*BITS-1:BITS];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (io.start) state_nx = CALC;
      CALC:    if (cnt == CW'(BITS-1)) state_nx = FIX;
      FIX:     state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= '0;
      rd_q      <= '0;
      m_q       <= '0;
      hi        <= '0;
      lo        <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      special_q <= 1'b0;
      cnt       <= '0;
      result_q  <= '0;
      rd_out_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state == FIX);
      case (state)
        IDLE: if (io.start) begin
          op_q      <= op_in;
          rd_q      <= io.rd_in;
          neg_q     <= a_neg ^ b_neg;
          neg_r     <= a_neg;
          special_q <= special;
          m_q       <= is_div ? b_mag : a_mag;
          lo        <= is_div ? a_mag : b_mag;
          // Special cases occupy a single frozen CALC slot (counter preset to the last
          // iteration) so their done pulse lands two cycles after accept.
          hi        <= special ? spec_val : '0;
          cnt       <= special ? CW'(BITS-1) : '0;
        end
        CALC: begin
          cnt <= cnt + CW'(1);
          if (!special_q) begin
            if (op_q[2]) begin
              hi <= div_ge ? div_sub : div_sh[BITS-1:0];
              lo <= {lo[BITS-2:0], div_ge};
            end else begin
              hi <= mul_sum[BITS:1];
              lo <= {mul_sum[0], lo[BITS-1:1]};
            end
          end
        end
        FIX: begin
          result_q <= fix_val;
          rd_out_q <= rd_q;
        end
        default: ;
      endcase
    end
  end

  assign io.busy   = (state != IDLE);
  assign io.done   = done_q;
  assign io.result = result_q;
  assign io.rd_out = rd_out_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: expected results are queued at issue and checked when done pulses.
module tb_muldiv_unit;
  localparam int BITS = 64;
  localparam int REGS = 32;

  typedef struct packed {
    logic [63:0] res;
    logic [4:0]  rd;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   done_cnt = 0;
  exp_t sb[$];

  muldiv_unit_if #(.BITS(BITS), .REGS(REGS)) bus ();

  muldiv_unit #(.BITS(BITS), .REGS(REGS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Scoreboard: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      done_cnt++;
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_done result=%h rd=%0d with empty queue", bus.result, bus.rd_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bus.result !== e.res || bus.rd_out !== e.rd) begin
          failures++;
          $display("FAIL sb_result got result=%h rd=%0d expected result=%h rd=%0d",
                   bus.result, bus.rd_out, e.res, e.rd);
        end
      end
    end
  end

  task automatic push_exp(input logic [63:0] res, input logic [4:0] rd);
    exp_t e;
    e.res = res;
    e.rd  = rd;
    sb.push_back(e);
  endtask

  task automatic drive_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                           input logic [4:0] rd);
    bus.start    = 1'b1;
    bus.op       = op;
    bus.rs1_data = a;
    bus.rs2_data = b;
    bus.rd_in    = rd;
  endtask

  // Presents a request at a negedge, returns the cycle number of the accepting edge,
  // then scrambles the operands since the unit must not depend on them afterwards.
  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output int acc);
    @(negedge clk);
    drive_req(op, a, b, rd);
    @(posedge clk);
    #1;
    acc = cyc;
    bus.start    = 1'b0;
    bus.rs1_data = {$urandom, $urandom};
    bus.rs2_data = {$urandom, $urandom};
    bus.rd_in    = 5'($urandom);
    bus.op       = 3'($urandom);
  endtask

  // Returns cycles from accept to the done pulse, or -1 if it never came.
  task automatic wait_done(input int acc, input int budget, output int lat);
    lat = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        lat = cyc - acc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = '0; bus.rs1_data = '0; bus.rs2_data = '0; bus.rd_in = '0;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 64'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    checks++; if (bus.rd_out !== 5'd0) begin failures++; $display("FAIL reset_rd got=%0d exp=0", bus.rd_out); end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int acc, lat;
    push_exp(64'hFFFF_FFFF_FFFF_FFEB, 5'd5);
    issue(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, acc);
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL mul_busy_at_accept got=%b exp=1", bus.busy); end
    wait_done(acc, 100, lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL mul_latency got=%0d exp=65", lat); end
    @(negedge clk);
    checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      failures++; $display("FAIL mul_after_done busy=%b done=%b exp 0 0", bus.busy, bus.done); end
    checks++; if (bus.result !== 64'hFFFF_FFFF_FFFF_FFEB || bus.rd_out !== 5'd5) begin
      failures++; $display("FAIL mul_hold result=%h rd=%0d exp ffffffffffffffeb 5", bus.result, bus.rd_out); end
  endtask

  task automatic run_table(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [4:0] rd, input logic [63:0] res,
                           input int exp_lat);
    int acc, lat;
    push_exp(res, rd);
    issue(op, a, b, rd, acc);
    wait_done(acc, 100, lat);
    checks++; if (lat !== exp_lat) begin failures++; $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat); end
    @(negedge clk);
  endtask

  task automatic test_mulh();
    run_table("mulhu",  3'b011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd1, 64'hFFFF_FFFF_FFFF_FFFE, 65);
    run_table("mulh",   3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd2, 64'd0, 65);
    run_table("mulhsu", 3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF, 65);
  endtask

  task automatic test_div();
    run_table("div",  3'b100, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, 64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_table("rem",  3'b110, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd11, 64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_table("divu", 3'b101, 64'd100, 64'd7, 5'd12, 64'd14, 65);
    run_table("remu", 3'b111, 64'd100, 64'd7, 5'd13, 64'd2, 65);
  endtask

  task automatic test_special();
    run_table("divu_by0", 3'b101, 64'd5, 64'd0, 5'd20, 64'hFFFF_FFFF_FFFF_FFFF, 2);
    run_table("rem_by0",  3'b110, 64'd5, 64'd0, 5'd21, 64'd5, 2);
    run_table("div_ovf",  3'b100, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd22,
              64'h8000_0000_0000_0000, 2);
    run_table("rem_ovf",  3'b110, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd23, 64'd0, 2);
  endtask

  task automatic test_ignore_start();
    int acc, lat, d0;
    logic stayed_idle;
    d0 = done_cnt;
    push_exp(64'd99, 5'd7);
    issue(3'b000, 64'd9, 64'd11, 5'd7, acc);
    repeat (10) @(negedge clk);
    drive_req(3'b000, 64'd2, 64'd2, 5'd9);
    @(posedge clk); #1 bus.start = 1'b0;
    wait_done(acc, 100, lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL ignore_latency got=%0d exp=65", lat); end
    drive_req(3'b101, 64'd50, 64'd5, 5'd30);
    @(posedge clk); #1 bus.start = 1'b0;
    stayed_idle = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.busy !== 1'b0) stayed_idle = 1'b0;
    end
    checks++; if (stayed_idle !== 1'b1) begin failures++; $display("FAIL ignore_busy got=busy exp=idle"); end
    checks++; if (done_cnt - d0 !== 1) begin failures++; $display("FAIL ignore_done_count got=%0d exp=1", done_cnt - d0); end
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL ignore_queue got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_reset_abort();
    int acc, lat, d0;
    issue(3'b000, 64'h1234_5678, 64'h9ABC, 5'd17, acc);
    repeat (30) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL abort_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin failures++; $display("FAIL abort_done got=%b exp=0", bus.done); end
    checks++; if (bus.result !== 64'd0) begin failures++; $display("FAIL abort_result got=%h exp=0", bus.result); end
    @(negedge clk);
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (80) @(negedge clk);
    checks++; if (done_cnt !== d0 || bus.busy !== 1'b0) begin
      failures++; $display("FAIL abort_no_done pulses=%0d busy=%b exp 0 0", done_cnt - d0, bus.busy); end
    push_exp(64'd12, 5'd3);
    issue(3'b000, 64'd3, 64'd4, 5'd3, acc);
    wait_done(acc, 100, lat);
    checks++; if (lat !== 65) begin failures++; $display("FAIL post_reset_latency got=%0d exp=65", lat); end
    repeat (2) @(negedge clk);
    checks++; if (sb.size() !== 0) begin failures++; $display("FAIL final_queue got=%0d exp=0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_ignore_start();
    test_reset_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
